// File: rtl/parity_afu_engine.sv
// Streaming parity engine: job-control FSM, one-stage beat register, per-granule parity
// generation and a job-wide parity signature. Optional input parity check: PARITY_AFU_CHECK_EN.
module parity_afu_engine #(
  parameter int DATA_WIDTH  = 512,
  parameter int PAR_GRAN    = 64,
  parameter int COUNT_WIDTH = 16,
  parameter bit ODD         = 1'b1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             job_valid,
  input  logic [7:0]                       job_command,
  input  logic [COUNT_WIDTH-1:0]           cfg_beats,
  output logic                             job_running,
  output logic                             job_done,
  output logic                             job_error,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic [DATA_WIDTH/PAR_GRAN-1:0]   in_par,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [DATA_WIDTH/PAR_GRAN-1:0]   out_par,
  output logic [DATA_WIDTH/PAR_GRAN-1:0]   acc_parity,
  output logic [COUNT_WIDTH-1:0]           beat_count
);
  localparam int NPAR = DATA_WIDTH / PAR_GRAN;
  localparam logic [7:0] CMD_START = 8'h90;
  localparam logic [7:0] CMD_RESET = 8'h80;

  // state   | meaning
  // IDLE    | no job since reset / RESET command
  // RUNNING | accepting beats until cfg_beats have been taken
  // DRAIN   | all beats taken, waiting for the last one to leave
  // DONE    | job finished, signature and count held
  typedef enum logic [1:0] {IDLE, RUNNING, DRAIN, DONE} state_t;

  state_t state, state_next;

  logic                   cmd_reset, cmd_start, start_ok, start_bad;
  logic                   accept, consume, last_beat;
  logic [NPAR-1:0]        gran_par;
  logic [COUNT_WIDTH-1:0] cfg_len;

  for (genvar i = 0; i < NPAR; i++) begin : g_par
    assign gran_par[i] = ^in_data[i*PAR_GRAN +: PAR_GRAN];
  end

  assign cmd_reset   = job_valid && (job_command == CMD_RESET);
  assign cmd_start   = job_valid && (job_command == CMD_START);
  assign start_ok    = cmd_start && ((state == IDLE) || (state == DONE));
  assign start_bad   = cmd_start && ((state == RUNNING) || (state == DRAIN));
  assign in_ready    = (state == RUNNING) && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign consume     = out_valid && out_ready;
  assign last_beat   = (beat_count + COUNT_WIDTH'(1)) == cfg_len;
  assign job_running = (state == RUNNING) || (state == DRAIN);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start_ok) state_next = (cfg_beats == '0) ? DONE : RUNNING;
      RUNNING:    if (accept && last_beat) state_next = DRAIN;
      DRAIN:      if (consume) state_next = DONE;
      default:    state_next = IDLE;
    endcase
    if (cmd_reset) state_next = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset || cmd_reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_par    <= '0;
      acc_parity <= '0;
      beat_count <= '0;
      cfg_len    <= '0;
      job_done   <= 1'b0;
      job_error  <= 1'b0;
    end else begin
      job_done <= ((state == DRAIN) && consume) || (start_ok && (cfg_beats == '0));
      if (start_ok) begin
        cfg_len    <= cfg_beats;
        beat_count <= '0;
        acc_parity <= '0;
        job_error  <= 1'b0;
      end else if (start_bad) begin
        job_error <= 1'b1;
      end
      // accept and drain may coincide; out_valid then simply stays high
      if (accept) begin
        out_data   <= in_data;
        out_par    <= gran_par ^ {NPAR{ODD}};
        acc_parity <= acc_parity ^ gran_par;
        beat_count <= beat_count + COUNT_WIDTH'(1);
        out_valid  <= 1'b1;
      end else if (consume) begin
        out_valid <= 1'b0;
      end
`ifdef PARITY_AFU_CHECK_EN
      if (accept && (in_par != (gran_par ^ {NPAR{ODD}}))) job_error <= 1'b1;
`endif
    end
  end

`ifndef PARITY_AFU_CHECK_EN
  logic unused_in_par;
  assign unused_in_par = ^in_par;
`endif

endmodule

// File: tb/tb_parity_afu_engine.sv
// Randomized bench for parity_afu_engine against a job-level behavioural model.
module tb_parity_afu_engine;
  localparam int DW   = 512;
  localparam int GR   = 64;
  localparam int NPAR = DW / GR;
  localparam int CW   = 16;
  localparam logic ODD = 1'b1;
`ifdef PARITY_AFU_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset, job_valid, in_valid, out_ready;
  logic [7:0]      job_command;
  logic [CW-1:0]   cfg_beats;
  logic            job_running, job_done, job_error, in_ready, out_valid;
  logic [DW-1:0]   in_data, out_data;
  logic [NPAR-1:0] in_par, out_par, acc_parity;
  logic [CW-1:0]   beat_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  parity_afu_engine dut (
    .clock(clock), .reset(reset), .job_valid(job_valid), .job_command(job_command),
    .cfg_beats(cfg_beats), .job_running(job_running), .job_done(job_done),
    .job_error(job_error), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_par(in_par), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_par(out_par), .acc_parity(acc_parity), .beat_count(beat_count)
  );

  typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE} phase_t;
  phase_t          m_phase;
  logic            m_valid, m_done, m_err;
  logic [DW-1:0]   m_data;
  logic [NPAR-1:0] m_opar, m_acc;
  int              m_count, m_len;

  // parity by counting ones per granule
  function automatic logic [NPAR-1:0] gran_parity(logic [DW-1:0] d);
    logic [NPAR-1:0] p;
    logic [GR-1:0]   g;
    for (int i = 0; i < NPAR; i++) begin
      g = d[i*GR +: GR];
      p[i] = ($countones(g) % 2) == 1;
    end
    return p;
  endfunction

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] d;
    for (int k = 0; k < DW/32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic check(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    m_phase = M_IDLE; m_valid = 0; m_done = 0; m_err = 0;
    m_data = '0; m_opar = '0; m_acc = '0; m_count = 0; m_len = 0;
  endtask

  task automatic set_idle();
    reset = 0; job_valid = 0; job_command = 8'h00; cfg_beats = '0;
    in_valid = 0; out_ready = 0; in_data = '0; in_par = '0;
  endtask

  // one clock: predict from current inputs, advance, compare every output
  task automatic cycle();
    logic            take, give;
    logic [NPAR-1:0] p;
    take = (m_phase == M_RUN) && (!m_valid || out_ready) && in_valid;
    give = m_valid && out_ready;
    p = gran_parity(in_data);
    @(posedge clock); #1;
    if (reset || (job_valid && job_command == 8'h80)) begin
      model_clear();
    end else begin
      m_done = 0;
      if (job_valid && job_command == 8'h90) begin
        if (m_phase == M_IDLE || m_phase == M_DONE) begin
          m_len = int'(cfg_beats); m_count = 0; m_acc = '0; m_err = 0;
          if (m_len == 0) begin m_phase = M_DONE; m_done = 1; end
          else m_phase = M_RUN;
        end else m_err = 1;
      end
      if (take) begin
        m_data = in_data; m_opar = p ^ {NPAR{ODD}}; m_acc = m_acc ^ p;
        m_count++; m_valid = 1;
        if (m_count == m_len) m_phase = M_DRAIN;
        if (CHECK_EN && in_par != (p ^ {NPAR{ODD}})) m_err = 1;
      end else if (give) begin
        m_valid = 0;
        if (m_phase == M_DRAIN) begin m_phase = M_DONE; m_done = 1; end
      end
    end
    check("out_valid", out_valid, m_valid);
    check("out_data", out_data, m_data);
    check("out_par", out_par, m_opar);
    check("acc_parity", acc_parity, m_acc);
    check("beat_count", beat_count, m_count[CW-1:0]);
    check("job_running", job_running, (m_phase == M_RUN) || (m_phase == M_DRAIN));
    check("job_done", job_done, m_done);
    check("job_error", job_error, m_err);
    check("in_ready", in_ready, (m_phase == M_RUN) && (!m_valid || out_ready));
  endtask

  task automatic run_job(int len, int bad_start_at, int reset_at, bit flip3);
    bit bad_sent = 0;
    set_idle();
    job_valid = 1; job_command = 8'h90; cfg_beats = CW'(len);
    cycle();
    for (int c = 0; c < 40*len + 20 && (m_phase == M_RUN || m_phase == M_DRAIN); c++) begin
      set_idle();
      in_valid  = ($urandom_range(3) != 0);
      in_data   = rand_beat();
      in_par    = gran_parity(in_data) ^ {NPAR{ODD}};
      if (flip3 && m_count == 0) in_par[3] = ~in_par[3];
      out_ready = ($urandom_range(2) != 0);
      if (m_count == bad_start_at && !bad_sent) begin
        job_valid = 1; job_command = 8'h90; cfg_beats = CW'($urandom); bad_sent = 1;
      end else if (m_count == reset_at) begin
        job_valid = 1; job_command = 8'h80;
      end else if ($urandom_range(7) == 0) begin
        job_valid = 1; job_command = 8'h55;
      end
      cycle();
    end
    set_idle();
    cycle();
    check("job_finished", job_running, 1'b0);
  endtask

  initial begin
    model_clear();
    set_idle();
    reset = 1; in_valid = 1; out_ready = 1; in_data = rand_beat();
    cycle();
    cycle();
    check("reset_in_ready", in_ready, 1'b0);

    // single beat 512'h1
    set_idle();
    job_valid = 1; job_command = 8'h90; cfg_beats = 1;
    cycle();
    set_idle();
    in_valid = 1; in_data = 1; in_par = 8'hFE;
    cycle();
    set_idle();
    check("single_out_par", out_par, 8'hFE);
    check("single_acc", acc_parity, 8'h01);
    out_ready = 1;
    cycle();
    check("single_done_pulse", job_done, 1'b1);
    cycle();
    check("single_count", beat_count, 1);

    // 4 beats with a 3-cycle stall after beat 2
    set_idle();
    job_valid = 1; job_command = 8'h90; cfg_beats = 4;
    cycle();
    for (int c = 0; c < 12; c++) begin
      set_idle();
      in_valid = 1; in_data = rand_beat(); in_par = gran_parity(in_data) ^ {NPAR{ODD}};
      out_ready = (c >= 2 && c < 5) ? 1'b0 : 1'b1;
      cycle();
    end
    check("bp_count", beat_count, 4);

    run_job(0, -1, -1, 0);
    run_job(6, 2, -1, 0);
    check("bad_start_error", job_error, 1'b1);
    run_job(8, -1, 2, 0);
    check("reset_mid_count", beat_count, 0);
    run_job(5, -1, -1, 0);
    run_job(3, -1, -1, 1);
    check("flip_error", job_error, CHECK_EN);
    for (int j = 0; j < 6; j++) run_job($urandom_range(12, 1), -1, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
